ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction fetcher feeding the issue-stage decoder.
- Fetches 32-bit windows from the icache at halfword-aligned PCs and sizes each instruction (RV32I plus C extension).
- Predicts the next PC for branches and jumps, and presents one instruction at a time to the decoder.
- Obeys decoder stall and JALR redirect, and ROB mispredict flushes.

Parameters:
- RESET_PC, 32'h0, fetch PC after reset.
- BHT_ENTRIES, 64, number of 2-bit counters, power of 2, indexed by pc[log2(BHT_ENTRIES):1].

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset; one clock; reset is synchronous and active-low.
- rdy_in  input  1  global ready; low freezes all state and holds all outputs.
- icache_req_valid  output  1  fetch request.
- icache_req_addr  output  32  halfword-aligned fetch PC.
- icache_req_ready  input  1  request accepted this cycle.
- icache_resp_valid  input  1  response strobe, at most one outstanding request.
- icache_resp_data  input  32  32 bits starting at icache_req_addr.
- ins_ready  output  1  instruction valid to decoder.
- ins  output  32  instruction word; upper half don't-care when 16-bit.
- pc  output  32  {pc[31:1], taken}; bit0 = conditional branch predicted taken.
- predict_nxt_pc  output  32  predicted next PC.
- IFetcher_stall  input  1  decoder cannot accept the presented instruction (combinational).
- IFetcher_clear  input  1  JALR target resolved (one-cycle pulse).
- IFetcher_new_addr  input  32  JALR target.
- rob_clear  input  1  mispredict flush.
- rob_new_pc  input  32  flush target.
- bht_upd_valid  input  1  retired conditional branch.
- bht_upd_pc  input  32  PC of the retired branch.
- bht_upd_taken  input  1  actual outcome of the retired branch.

Behaviour:
- Reset (rst_in==0 at posedge):
  - fetch_pc=RESET_PC, state=S_REQ.
  - Outputs: ins_ready=0, ins=0, pc=0, predict_nxt_pc=0, icache_req_valid=0.
  - All BHT counters = 2'b01 (weakly not-taken).
  - Reset overrides everything, including a mid-flight request; a late response after reset is dropped via S_DROP semantics only if the request was outstanding.
- States: S_REQ, S_WAIT, S_HOLD, S_JALR, S_DROP.
- S_REQ:
  - icache_req_valid=1, addr=fetch_pc.
  - icache_req_ready → S_WAIT.
- S_WAIT:
  - On icache_resp_valid, register ins=data.
  - len=4 if data[1:0]==2'b11, else 2.
  - Compute prediction; assert ins_ready next cycle → S_HOLD.
- S_HOLD:
  - ins, pc, predict_nxt_pc and ins_ready are held stable while IFetcher_stall=1.
  - Accept = ins_ready && !IFetcher_stall; ins_ready drops the next cycle.
  - Each instruction is visible for exactly one accepted cycle.
  - If the instruction is a JALR → S_JALR. Otherwise fetch_pc=predict_nxt_pc → S_REQ.
- JALR detection:
  - 32-bit opcode 1100111.
  - C.JR/C.JALR: [1:0]=10, [15:13]=100, [6:2]=0, [11:7]≠0.
- S_JALR:
  - ins_ready=0, no requests.
  - On IFetcher_clear: fetch_pc=IFetcher_new_addr & ~1 → S_REQ.
- Prediction (32-bit arithmetic, wrap modulo 2^32):
  - JAL: target = pc + sext(immJ).
  - C.J/C.JAL (q01, funct3 101/001): target = pc + sext({i[12],i[8],i[10:9],i[6],i[7],i[2],i[11],i[5:3],0}).
  - For JAL, C.J and C.JAL: always redirect; pc[0]=0.
  - B-type: target = pc + sext(immB).
  - C.BEQZ/BNEZ (q01, funct3 11x): target = pc + sext({i[12],i[6:5],i[2],i[11:10],i[4:3],0}).
  - For conditional branches: taken = predictor; pc[0]=taken; predict_nxt_pc = taken ? target : pc+len.
  - Others: predict_nxt_pc = pc+len.
- Flush (rob_clear, highest priority over IFetcher_clear and accept):
  - ins_ready=0 next cycle; fetch_pc = rob_new_pc & ~1.
  - Goes to S_DROP if a request is outstanding (S_WAIT without resp this cycle, or S_REQ with req_ready this cycle); otherwise S_REQ.
- S_DROP: discard the next icache response → S_REQ.
- Flush coincident with resp_valid in S_WAIT: response discarded → S_REQ.
- BHT update:
  - Saturating ±1 at index of bht_upd_pc.
  - Read and write of the same index in the same cycle: read returns the old value.

Optional Feature:
- IFETCH_BHT_EN
  - Defined: conditional branches use the 2-bit BHT (taken iff counter[1]); bht_upd_* trains it.
  - Undefined: static BTFN (taken iff offset negative); no BHT storage; bht_upd_* ignored.

Decomposition:
- Shared const.v additions: state encodings, opcode localparams (RISC_B, JAL, JALR), RVC quadrant codes, BHT reset value.
- Sub-module branch_history_table: BHT_ENTRIES x 2-bit, one combinational read port, one synchronous update port, synchronous active-low reset.
- branch_history_table is instantiated only under IFETCH_BHT_EN.

Test Plan:
- Straight-line code:
  - Stimulus: reset, RESET_PC=0; icache returns addi (32'h00100093) @0, c.addi (16'h0505) @4, addi @6; no stall.
  - Required: pc=0,4,6 with predict_nxt_pc=4,6,10.
- Stall hold:
  - Stimulus: IFetcher_stall=1 for 5 cycles on ins @0x10.
  - Required: ins/pc/predict_nxt_pc unchanged, no icache request until stall drops.
- Backward branch:
  - Stimulus: bne @0x20 offset -16.
  - Required: BTFN predicts taken (pc=0x21, predict_nxt_pc=0x10); with BHT after reset, not-taken (predict_nxt_pc=0x24).
  - Required: after two bht_upd_taken=1 at 0x20, pc=0x21.
- JALR:
  - Stimulus: jalr @0x30 accepted; IFetcher_clear after 3 cycles with new_addr 0x101.
  - Required: ins_ready low meanwhile; next req_addr=0x100.
- Flush during outstanding fetch:
  - Stimulus: rob_clear with rob_new_pc=0x200 while in S_WAIT; stale response arrives next cycle.
  - Required: stale response discarded; next request addr=0x200.
- Reset mid-S_HOLD:
  - Stimulus: rst_in=0 while in S_HOLD.
  - Required: ins_ready=0 next cycle; first request addr=RESET_PC.

Source files
------------

// File: rtl/ifetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_unit_pkg
// Description : Shared constants and helpers for the instruction fetcher.
//               Contains the fetch FSM state encodings, the RV32 opcodes the
//               fetcher decodes (RISC_B, JAL, JALR), the RVC quadrant codes,
//               the BHT counter reset value, the JALR detector and the
//               saturating-counter update.
// Revision    : 1.0 - initial release
// ============================================================================
package ifetch_unit_pkg;

    // Fetch FSM state encodings
    localparam int c_state_w = 3;
    localparam logic [c_state_w-1:0] S_REQ  = 3'd0;
    localparam logic [c_state_w-1:0] S_WAIT = 3'd1;
    localparam logic [c_state_w-1:0] S_HOLD = 3'd2;
    localparam logic [c_state_w-1:0] S_JALR = 3'd3;
    localparam logic [c_state_w-1:0] S_DROP = 3'd4;

    // RV32I opcodes relevant to next-PC prediction
    localparam logic [6:0] c_op_risc_b = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;

    // RVC quadrant codes (instruction bits [1:0])
    localparam logic [1:0] c_rvc_q1 = 2'b01;
    localparam logic [1:0] c_rvc_q2 = 2'b10;

    // Branch history counters start weakly not-taken
    localparam logic [1:0] c_bht_reset = 2'b01;

    // True for JALR and for C.JR / C.JALR. Within quadrant 2, funct3=100 with
    // rs2=0 and rs1!=0 selects exactly the register-indirect jumps; rs2!=0
    // would be C.MV/C.ADD and rs1=0 would be C.EBREAK.
    function automatic logic is_jalr(input logic [31:0] ins);
        logic v_full;
        logic v_comp;
        v_full = (ins[1:0] == 2'b11) && (ins[6:0] == c_op_jalr);
        v_comp = (ins[1:0] == c_rvc_q2) && (ins[15:13] == 3'b100) &&
                 (ins[6:2] == 5'd0) && (ins[11:7] != 5'd0);
        return v_full || v_comp;
    endfunction

    // Saturating +/-1 update of a 2-bit branch counter
    function automatic logic [1:0] bht_next(input logic [1:0] ctr,
                                             input logic       taken);
        logic [1:0] v_next;
        if (taken) begin
            v_next = (ctr == 2'b11) ? ctr : ctr + 2'd1;
        end else begin
            v_next = (ctr == 2'b00) ? ctr : ctr - 2'd1;
        end
        return v_next;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_unit_bht.sv
`default_nettype none
// ============================================================================
// Module      : branch_history_table
// Description : Table of BHT_ENTRIES 2-bit saturating branch counters.
//               One combinational read port, one synchronous update port.
//               A read and an update of the same entry in the same cycle
//               returns the value held before the update.
// Ports       : clk_in     - clock
//               rst_in     - synchronous active-low reset (all = weakly NT)
//               rdy_in     - global ready; low freezes the table
//               rd_idx     - read index
//               rd_ctr     - counter at rd_idx
//               upd_valid  - apply an update this cycle
//               upd_idx    - entry to update
//               upd_taken  - actual branch outcome
// Revision    : 1.0 - initial release
// ============================================================================
module branch_history_table
    import ifetch_unit_pkg::*;
#(
    parameter int BHT_ENTRIES = 64
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           rdy_in,
    input  logic [$clog2(BHT_ENTRIES)-1:0] rd_idx,
    output logic [1:0]                     rd_ctr,
    input  logic                           upd_valid,
    input  logic [$clog2(BHT_ENTRIES)-1:0] upd_idx,
    input  logic                           upd_taken
);

    logic [1:0] r_ctr [BHT_ENTRIES];

    assign rd_ctr = r_ctr[rd_idx];

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int k = 0; k < BHT_ENTRIES; k++) begin
                r_ctr[k] <= c_bht_reset;
            end
        end else if (rdy_in && upd_valid) begin
            r_ctr[upd_idx] <= bht_next(r_ctr[upd_idx], upd_taken);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_unit
// Description : Instruction fetcher for RV32I + C. Requests 32-bit windows
//               from the icache at halfword-aligned PCs, sizes the returned
//               instruction, predicts the next PC and presents one
//               instruction at a time to the decoder. Handles decoder stall,
//               JALR redirect and ROB mispredict flush.
// Build option: IFETCH_BHT_EN - defined: conditional branches predicted by a
//               2-bit BHT trained via bht_upd_*; undefined: static
//               backward-taken / forward-not-taken, bht_upd_* ignored.
// Ports       : clk_in, rst_in (sync, active-low), rdy_in (freeze when low)
//               icache_req_valid/addr/ready  - fetch request channel
//               icache_resp_valid/data       - fetch response channel
//               ins_ready, ins, pc, predict_nxt_pc - decoder interface
//               IFetcher_stall/clear/new_addr - decoder stall and JALR target
//               rob_clear, rob_new_pc        - mispredict flush
//               bht_upd_valid/pc/taken       - retired branch training
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int          BHT_ENTRIES = 64
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        icache_req_valid,
    output logic [31:0] icache_req_addr,
    input  logic        icache_req_ready,
    input  logic        icache_resp_valid,
    input  logic [31:0] icache_resp_data,
    output logic        ins_ready,
    output logic [31:0] ins,
    output logic [31:0] pc,
    output logic [31:0] predict_nxt_pc,
    input  logic        IFetcher_stall,
    input  logic        IFetcher_clear,
    input  logic [31:0] IFetcher_new_addr,
    input  logic        rob_clear,
    input  logic [31:0] rob_new_pc,
    input  logic        bht_upd_valid,
    input  logic [31:0] bht_upd_pc,
    input  logic        bht_upd_taken
);

    logic [c_state_w-1:0] r_state;
    logic [31:0]          r_fetch_pc;
    logic                 r_req_valid;
    logic                 r_ins_ready;
    logic [31:0]          r_ins;
    logic [31:0]          r_pc;
    logic [31:0]          r_pred;

    assign icache_req_valid = r_req_valid;
    assign icache_req_addr  = r_fetch_pc;
    assign ins_ready        = r_ins_ready;
    assign ins              = r_ins;
    assign pc               = r_pc;
    assign predict_nxt_pc   = r_pred;

    // ------------------------------------------------------------------
    // Decode of the returned window (valid while a response is arriving)
    // ------------------------------------------------------------------
    logic [31:0] w_d;
    logic        w_is32;
    logic        w_is_jal;
    logic        w_is_br;
    logic        w_is_cj;
    logic        w_is_cb;
    logic [31:0] w_seq_pc;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_cj;
    logic [31:0] w_imm_cb;
    logic        w_br_taken;
    logic [31:0] w_pred;
    logic        w_pc_bit0;

    assign w_d      = icache_resp_data;
    assign w_is32   = (w_d[1:0] == 2'b11);
    assign w_is_jal = w_is32 && (w_d[6:0] == c_op_jal);
    assign w_is_br  = w_is32 && (w_d[6:0] == c_op_risc_b);
    assign w_is_cj  = !w_is32 && (w_d[1:0] == c_rvc_q1) &&
                      ((w_d[15:13] == 3'b101) || (w_d[15:13] == 3'b001));
    assign w_is_cb  = !w_is32 && (w_d[1:0] == c_rvc_q1) && (w_d[15:14] == 2'b11);
    assign w_seq_pc = r_fetch_pc + (w_is32 ? 32'd4 : 32'd2);

    assign w_imm_j  = {{12{w_d[31]}}, w_d[19:12], w_d[20], w_d[30:21], 1'b0};
    assign w_imm_b  = {{20{w_d[31]}}, w_d[7], w_d[30:25], w_d[11:8], 1'b0};
    assign w_imm_cj = {{21{w_d[12]}}, w_d[8], w_d[10:9], w_d[6], w_d[7],
                       w_d[2], w_d[11], w_d[5:3], 1'b0};
    assign w_imm_cb = {{24{w_d[12]}}, w_d[6:5], w_d[2], w_d[11:10],
                       w_d[4:3], 1'b0};

    // Sink for inputs (or bits of inputs) the datapath never looks at
    logic w_unused_bits;

`ifdef IFETCH_BHT_EN
    localparam int c_idx_w = $clog2(BHT_ENTRIES);
    logic [1:0] w_bht_ctr;

    branch_history_table #(
        .BHT_ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .rd_idx    (r_fetch_pc[c_idx_w:1]),
        .rd_ctr    (w_bht_ctr),
        .upd_valid (bht_upd_valid),
        .upd_idx   (bht_upd_pc[c_idx_w:1]),
        .upd_taken (bht_upd_taken)
    );

    assign w_br_taken    = w_bht_ctr[1];
    assign w_unused_bits = ^{bht_upd_pc, rob_new_pc[0], IFetcher_new_addr[0]};
`else
    // Backward branches (negative offset) are predicted taken
    assign w_br_taken    = w_is32 ? w_d[31] : w_d[12];
    assign w_unused_bits = ^{bht_upd_valid, bht_upd_pc, bht_upd_taken,
                             rob_new_pc[0], IFetcher_new_addr[0],
                             BHT_ENTRIES[0]};
`endif

    always_comb begin
        w_pred    = w_seq_pc;
        w_pc_bit0 = 1'b0;
        if (w_is_jal) begin
            w_pred = r_fetch_pc + w_imm_j;
        end else if (w_is_cj) begin
            w_pred = r_fetch_pc + w_imm_cj;
        end else if (w_is_br) begin
            w_pc_bit0 = w_br_taken;
            w_pred    = w_br_taken ? (r_fetch_pc + w_imm_b) : w_seq_pc;
        end else if (w_is_cb) begin
            w_pc_bit0 = w_br_taken;
            w_pred    = w_br_taken ? (r_fetch_pc + w_imm_cb) : w_seq_pc;
        end
    end

    // A request is in flight if the icache owes us a response after this edge
    logic w_outstanding;
    assign w_outstanding = ((r_state == S_WAIT) && !icache_resp_valid) ||
                           ((r_state == S_DROP) && !icache_resp_valid) ||
                           ((r_state == S_REQ) && r_req_valid && icache_req_ready);

    logic w_hold_jalr;
    assign w_hold_jalr = is_jalr(r_ins);

    // ------------------------------------------------------------------
    // Fetch FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            // A reset that cuts off an accepted request must still swallow
            // the response that will eventually come back.
            if (w_outstanding) begin
                r_state <= S_DROP;
            end else begin
                r_state <= S_REQ;
            end
            r_fetch_pc  <= RESET_PC;
            r_req_valid <= 1'b0;
            r_ins_ready <= 1'b0;
            r_ins       <= 32'd0;
            r_pc        <= 32'd0;
            r_pred      <= 32'd0;
        end else if (rdy_in) begin
            if (rob_clear) begin
                r_ins_ready <= 1'b0;
                r_fetch_pc  <= {rob_new_pc[31:1], 1'b0};
                if (w_outstanding) begin
                    r_state     <= S_DROP;
                    r_req_valid <= 1'b0;
                end else begin
                    r_state     <= S_REQ;
                    r_req_valid <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_REQ: begin
                        // req_valid is low only on the first cycle after reset
                        if (!r_req_valid) begin
                            r_req_valid <= 1'b1;
                        end else if (icache_req_ready) begin
                            r_req_valid <= 1'b0;
                            r_state     <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (icache_resp_valid) begin
                            r_ins       <= icache_resp_data;
                            r_pc        <= {r_fetch_pc[31:1], w_pc_bit0};
                            r_pred      <= w_pred;
                            r_ins_ready <= 1'b1;
                            r_state     <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (r_ins_ready && !IFetcher_stall) begin
                            r_ins_ready <= 1'b0;
                            if (w_hold_jalr) begin
                                r_state <= S_JALR;
                            end else begin
                                r_fetch_pc  <= {r_pred[31:1], 1'b0};
                                r_req_valid <= 1'b1;
                                r_state     <= S_REQ;
                            end
                        end
                    end
                    S_JALR: begin
                        if (IFetcher_clear) begin
                            r_fetch_pc  <= {IFetcher_new_addr[31:1], 1'b0};
                            r_req_valid <= 1'b1;
                            r_state     <= S_REQ;
                        end
                    end
                    S_DROP: begin
                        if (icache_resp_valid) begin
                            r_req_valid <= 1'b1;
                            r_state     <= S_REQ;
                        end
                    end
                    default: begin
                        r_ins_ready <= 1'b0;
                        r_req_valid <= 1'b1;
                        r_state     <= S_REQ;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_unit
// Description : Directed self-checking bench for ifetch_unit. A halfword
//               memory backs a task-driven icache responder; each scenario
//               task compares DUT outputs against hand-computed values.
//               Expectations for the backward branch depend on IFETCH_BHT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        icache_req_valid;
    logic [31:0] icache_req_addr;
    logic        icache_req_ready;
    logic        icache_resp_valid;
    logic [31:0] icache_resp_data;
    logic        ins_ready;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] predict_nxt_pc;
    logic        IFetcher_stall;
    logic        IFetcher_clear;
    logic [31:0] IFetcher_new_addr;
    logic        rob_clear;
    logic [31:0] rob_new_pc;
    logic        bht_upd_valid;
    logic [31:0] bht_upd_pc;
    logic        bht_upd_taken;

    int n_cmp = 0;
    int n_mis = 0;

    logic [15:0] mem [0:1023];

    always #5 clk_in = ~clk_in;

    ifetch_unit #(
        .RESET_PC    (32'h0),
        .BHT_ENTRIES (64)
    ) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .icache_req_valid  (icache_req_valid),
        .icache_req_addr   (icache_req_addr),
        .icache_req_ready  (icache_req_ready),
        .icache_resp_valid (icache_resp_valid),
        .icache_resp_data  (icache_resp_data),
        .ins_ready         (ins_ready),
        .ins               (ins),
        .pc                (pc),
        .predict_nxt_pc    (predict_nxt_pc),
        .IFetcher_stall    (IFetcher_stall),
        .IFetcher_clear    (IFetcher_clear),
        .IFetcher_new_addr (IFetcher_new_addr),
        .rob_clear         (rob_clear),
        .rob_new_pc        (rob_new_pc),
        .bht_upd_valid     (bht_upd_valid),
        .bht_upd_pc        (bht_upd_pc),
        .bht_upd_taken     (bht_upd_taken)
    );

    task automatic put16(input logic [31:0] a, input logic [15:0] h);
        mem[int'(a[10:1])] = h;
    endtask

    task automatic put32(input logic [31:0] a, input logic [31:0] w);
        mem[int'(a[10:1])]     = w[15:0];
        mem[int'(a[10:1]) + 1] = w[31:16];
    endtask

    // Waits (bounded) for a request, accepts it, returns the window one cycle
    // later. Ends on the negedge where the instruction is presented. A
    // timeout reports 32'hDEADBEEF as the address so the caller's check fails.
    task automatic serve(output logic [31:0] addr);
        addr = 32'hDEAD_BEEF;
        for (int k = 0; k < 20; k++) begin
            if (icache_req_valid) begin
                addr = icache_req_addr;
                icache_req_ready = 1'b1;
                @(negedge clk_in);
                icache_req_ready  = 1'b0;
                icache_resp_valid = 1'b1;
                icache_resp_data  = {mem[int'(addr[10:1]) + 1], mem[int'(addr[10:1])]};
                @(negedge clk_in);
                icache_resp_valid = 1'b0;
                return;
            end
            @(negedge clk_in);
        end
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] a);
        rob_clear  = 1'b1;
        rob_new_pc = a;
        @(negedge clk_in);
        rob_clear  = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        n_cmp++;
        if ({ins_ready, icache_req_valid} !== 2'b00) begin
            n_mis++;
            $display("FAIL reset_valids: got ins_ready=%b req_valid=%b, want 0 0", ins_ready, icache_req_valid);
        end
        n_cmp++;
        if ({ins, pc, predict_nxt_pc} !== 96'd0) begin
            n_mis++;
            $display("FAIL reset_regs: got ins=%h pc=%h pred=%h, want all 0", ins, pc, predict_nxt_pc);
        end
        rst_in = 1'b1;
        @(negedge clk_in);
        n_cmp++;
        if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h0) begin
            n_mis++;
            $display("FAIL reset_first_req: got valid=%b addr=%h, want 1 00000000", icache_req_valid, icache_req_addr);
        end
    endtask

    task automatic test_straight();
        logic [31:0] a;
        logic [31:0] exp_pc [3];
        logic [31:0] exp_pred [3];
        exp_pc   = '{32'h0, 32'h4, 32'h6};
        exp_pred = '{32'h4, 32'h6, 32'hA};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            serve(a);
            n_cmp++;
            if (a !== exp_pc[i]) begin
                n_mis++;
                $display("FAIL straight_addr[%0d]: got %h, want %h", i, a, exp_pc[i]);
            end
            n_cmp++;
            if (ins_ready !== 1'b1 || pc !== exp_pc[i] || predict_nxt_pc !== exp_pred[i]) begin
                n_mis++;
                $display("FAIL straight_pred[%0d]: got rdy=%b pc=%h pred=%h, want 1 %h %h",
                         i, ins_ready, pc, predict_nxt_pc, exp_pc[i], exp_pred[i]);
            end
        end
        n_cmp++;
        if (ins !== 32'h0010_0093) begin
            n_mis++;
            $display("FAIL straight_ins: got %h, want 00100093", ins);
        end
    endtask

    task automatic test_stall();
        logic [31:0] a;
        do_reset();
        redirect(32'h10);
        serve(a);
        n_cmp++;
        if (a !== 32'h10) begin
            n_mis++;
            $display("FAIL stall_addr: got %h, want 00000010", a);
        end
        IFetcher_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            n_cmp++;
            if (ins_ready !== 1'b1 || ins !== 32'h0010_0093 || pc !== 32'h10 ||
                predict_nxt_pc !== 32'h14 || icache_req_valid !== 1'b0) begin
                n_mis++;
                $display("FAIL stall_hold[%0d]: got rdy=%b ins=%h pc=%h pred=%h req=%b, want 1 00100093 10 14 0",
                         i, ins_ready, ins, pc, predict_nxt_pc, icache_req_valid);
            end
        end
        IFetcher_stall = 1'b0;
        @(negedge clk_in);
        n_cmp++;
        if (ins_ready !== 1'b0 || icache_req_valid !== 1'b1 || icache_req_addr !== 32'h14) begin
            n_mis++;
            $display("FAIL stall_release: got rdy=%b req=%b addr=%h, want 0 1 00000014",
                     ins_ready, icache_req_valid, icache_req_addr);
        end
    endtask

    task automatic test_branch();
        logic [31:0] a;
        logic [31:0] e_pc;
        logic [31:0] e_pred;
`ifdef IFETCH_BHT_EN
        e_pc   = 32'h20;
        e_pred = 32'h24;
`else
        e_pc   = 32'h21;
        e_pred = 32'h10;
`endif
        do_reset();
        redirect(32'h20);
        serve(a);
        n_cmp++;
        if (a !== 32'h20 || pc !== e_pc || predict_nxt_pc !== e_pred) begin
            n_mis++;
            $display("FAIL branch_first: got addr=%h pc=%h pred=%h, want 20 %h %h", a, pc, predict_nxt_pc, e_pc, e_pred);
        end
        bht_upd_valid = 1'b1;
        bht_upd_pc    = 32'h20;
        bht_upd_taken = 1'b1;
        repeat (2) @(negedge clk_in);
        bht_upd_valid = 1'b0;
        redirect(32'h20);
        serve(a);
        n_cmp++;
        if (a !== 32'h20 || pc !== 32'h21 || predict_nxt_pc !== 32'h10) begin
            n_mis++;
            $display("FAIL branch_trained: got addr=%h pc=%h pred=%h, want 20 21 10", a, pc, predict_nxt_pc);
        end
    endtask

    task automatic test_jump();
        logic [31:0] a;
        do_reset();
        redirect(32'h50);
        serve(a);
        n_cmp++;
        if (a !== 32'h50 || pc !== 32'h50 || predict_nxt_pc !== 32'h58) begin
            n_mis++;
            $display("FAIL cj_pred: got addr=%h pc=%h pred=%h, want 50 50 58", a, pc, predict_nxt_pc);
        end
        serve(a);
        n_cmp++;
        if (a !== 32'h58 || pc !== 32'h58 || predict_nxt_pc !== 32'h40) begin
            n_mis++;
            $display("FAIL jal_pred: got addr=%h pc=%h pred=%h, want 58 58 40", a, pc, predict_nxt_pc);
        end
        serve(a);
        n_cmp++;
        if (a !== 32'h40) begin
            n_mis++;
            $display("FAIL jal_target_fetch: got %h, want 00000040", a);
        end
    endtask

    task automatic test_jalr();
        logic [31:0] a;
        do_reset();
        redirect(32'h30);
        serve(a);
        n_cmp++;
        if (a !== 32'h30 || ins_ready !== 1'b1 || ins !== 32'h0000_8067) begin
            n_mis++;
            $display("FAIL jalr_present: got addr=%h rdy=%b ins=%h, want 30 1 00008067", a, ins_ready, ins);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            n_cmp++;
            if (ins_ready !== 1'b0 || icache_req_valid !== 1'b0) begin
                n_mis++;
                $display("FAIL jalr_wait[%0d]: got rdy=%b req=%b, want 0 0", i, ins_ready, icache_req_valid);
            end
        end
        IFetcher_clear    = 1'b1;
        IFetcher_new_addr = 32'h101;
        @(negedge clk_in);
        IFetcher_clear = 1'b0;
        serve(a);
        n_cmp++;
        if (a !== 32'h100) begin
            n_mis++;
            $display("FAIL jalr_target: got %h, want 00000100", a);
        end
    endtask

    task automatic test_flush();
        logic [31:0] a;
        bit seen;
        do_reset();
        redirect(32'h70);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (icache_req_valid) seen = 1'b1;
            else @(negedge clk_in);
        end
        n_cmp++;
        if (!seen) begin
            n_mis++;
            $display("FAIL flush_req_seen: got no request within 20 cycles, want a request");
        end
        icache_req_ready = 1'b1;
        @(negedge clk_in);
        icache_req_ready = 1'b0;
        rob_clear  = 1'b1;
        rob_new_pc = 32'h200;
        @(negedge clk_in);
        rob_clear         = 1'b0;
        icache_resp_valid = 1'b1;
        icache_resp_data  = 32'hFE9F_F06F;
        @(negedge clk_in);
        icache_resp_valid = 1'b0;
        n_cmp++;
        if (ins_ready !== 1'b0 || icache_req_valid !== 1'b1 || icache_req_addr !== 32'h200) begin
            n_mis++;
            $display("FAIL flush_drop: got rdy=%b req=%b addr=%h, want 0 1 00000200",
                     ins_ready, icache_req_valid, icache_req_addr);
        end
        serve(a);
        n_cmp++;
        if (a !== 32'h200 || pc !== 32'h200 || predict_nxt_pc !== 32'h204) begin
            n_mis++;
            $display("FAIL flush_refetch: got addr=%h pc=%h pred=%h, want 200 200 204", a, pc, predict_nxt_pc);
        end
    endtask

    task automatic test_reset_hold();
        logic [31:0] a;
        do_reset();
        redirect(32'h60);
        serve(a);
        n_cmp++;
        if (a !== 32'h60 || ins_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL rsthold_present: got addr=%h rdy=%b, want 60 1", a, ins_ready);
        end
        IFetcher_stall = 1'b1;
        rst_in         = 1'b0;
        @(negedge clk_in);
        n_cmp++;
        if (ins_ready !== 1'b0 || pc !== 32'h0 || ins !== 32'h0) begin
            n_mis++;
            $display("FAIL rsthold_clear: got rdy=%b pc=%h ins=%h, want 0 0 0", ins_ready, pc, ins);
        end
        rst_in         = 1'b1;
        IFetcher_stall = 1'b0;
        serve(a);
        n_cmp++;
        if (a !== 32'h0) begin
            n_mis++;
            $display("FAIL rsthold_first_req: got %h, want 00000000", a);
        end
    endtask

    initial begin
        rst_in            = 1'b0;
        rdy_in            = 1'b1;
        icache_req_ready  = 1'b0;
        icache_resp_valid = 1'b0;
        icache_resp_data  = 32'h0;
        IFetcher_stall    = 1'b0;
        IFetcher_clear    = 1'b0;
        IFetcher_new_addr = 32'h0;
        rob_clear         = 1'b0;
        rob_new_pc        = 32'h0;
        bht_upd_valid     = 1'b0;
        bht_upd_pc        = 32'h0;
        bht_upd_taken     = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
        put32(32'h000, 32'h0010_0093);  // addi x1,x0,1
        put16(32'h004, 16'h0505);       // c.addi x10,1
        put32(32'h006, 32'h0010_0093);  // addi x1,x0,1
        put32(32'h010, 32'h0010_0093);  // addi x1,x0,1
        put32(32'h020, 32'hFE00_98E3);  // bne x1,x0,-16
        put32(32'h030, 32'h0000_8067);  // jalr x0,0(x1)
        put16(32'h050, 16'hA021);       // c.j +8
        put32(32'h058, 32'hFE9F_F06F);  // jal x0,-24
        put32(32'h200, 32'h0010_0093);  // addi x1,x0,1
        @(negedge clk_in);

        test_reset();
        test_straight();
        test_stall();
        test_branch();
        test_jump();
        test_jalr();
        test_flush();
        test_reset_hold();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
